// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM encoding and width defaults.
package mem_copy_engine_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_copy_engine_addr_gen.sv
// Address generator: holds source/destination base, length and byte count,
// produces wrapped read/write addresses and the last-byte flag.
module mem_copy_addr_gen
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              input_clk,
    input  logic              input_reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] rd_addr_nxt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LEN_W-1:0]  count,
    output logic              last
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;

    // Base registers latch on an accepted start; count advances once per written byte.
    always_ff @(posedge input_clk or negedge input_reset) begin
        if (!input_reset) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            count <= '0;
        end else if (load) begin
            src_q <= src_in;
            dst_q <= dst_in;
            len_q <= len_in;
            count <= '0;
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    // Addresses wrap naturally through the ADDR_W-bit add. The read address is
    // the one for the byte after the current count, since it is registered into
    // the port on the same edge that bumps count.
    assign rd_addr_nxt = src_q + ADDR_W'(count) + ADDR_W'(1);
    assign wr_addr     = dst_q + ADDR_W'(count);
    assign last        = ((count + LEN_W'(1)) == len_q);

endmodule

// File: rtl/mem_copy_engine.sv
// Byte-sequential memory copy engine: READ -> LATCH -> WRITE per byte, with a
// running mod-256 checksum of the written bytes and a one-cycle done pulse.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              input_clk,
    input  logic              input_reset,
    input  logic              input_start,
    input  logic              input_abort,
    input  logic [ADDR_W-1:0] input_Src,
    input  logic [ADDR_W-1:0] input_Dst,
    input  logic [LEN_W-1:0]  input_Length,
    input  logic [DATA_W-1:0] input_Readdata,
    output logic [ADDR_W-1:0] output_Address,
    output logic [DATA_W-1:0] output_Writedata,
    output logic              output_Memread,
    output logic              output_Memwrite,
    output logic              output_busy,
    output logic              output_done,
    output logic [LEN_W-1:0]  output_count,
    output logic [DATA_W-1:0] output_checksum
);

    state_t            state;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic              last;
    logic              accept;

    assign accept = (state == ST_IDLE) && input_start;

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .input_clk   (input_clk),
        .input_reset (input_reset),
        .load        (accept),
        .inc         (state == ST_WRITE),
        .src_in      (input_Src),
        .dst_in      (input_Dst),
        .len_in      (input_Length),
        .rd_addr_nxt (rd_addr_nxt),
        .wr_addr     (wr_addr),
        .count       (output_count),
        .last        (last)
    );

    // Copy FSM with registered strobes/address; the write in flight completes
    // even on abort, so count and checksum still advance in WRITE.
    always_ff @(posedge input_clk or negedge input_reset) begin
        if (!input_reset) begin
            state           <= ST_IDLE;
            data_q          <= '0;
            output_Address  <= '0;
            output_Memread  <= 1'b0;
            output_Memwrite <= 1'b0;
            output_done     <= 1'b0;
            output_checksum <= '0;
        end else begin
            output_Memread  <= 1'b0;
            output_Memwrite <= 1'b0;
            output_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (input_start) begin
                        output_checksum <= '0;
                        if (input_Length == '0) begin
                            state       <= ST_DONE;
                            output_done <= 1'b1;
                        end else begin
                            state          <= ST_READ;
                            output_Memread <= 1'b1;
                            output_Address <= input_Src;
                        end
                    end
                end
                ST_READ: begin
                    state <= input_abort ? ST_IDLE : ST_LATCH;
                end
                ST_LATCH: begin
                    data_q <= input_Readdata;
                    if (input_abort) begin
                        state <= ST_IDLE;
                    end else begin
                        state           <= ST_WRITE;
                        output_Memwrite <= 1'b1;
                        output_Address  <= wr_addr;
                    end
                end
                ST_WRITE: begin
                    output_checksum <= output_checksum + data_q;
                    if (input_abort) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state       <= ST_DONE;
                        output_done <= 1'b1;
                    end else begin
                        state          <= ST_READ;
                        output_Memread <= 1'b1;
                        output_Address <= rd_addr_nxt;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_busy      = (state != ST_IDLE);
    assign output_Writedata = data_q;

endmodule
